// File: rtl/rst_ctrl_if.sv
// MMIO bus bundle for the reset controller: select, strobes, word address, data and ready.
interface rst_ctrl_if;
  logic        sel;
  logic        we;
  logic        re;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rdy;

  modport master (output sel, we, re, addr, wdata, input rdata, rdy);
  modport slave  (input sel, we, re, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/rst_ctrl.sv
// Reset controller: merges power-on, debounced button, watchdog and software reset requests
// into a minimum-length system reset, with sticky cause flags exposed over a small MMIO bus.
module rst_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int RST_HOLD   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_n,
  input  logic       i_wdt_rst_req,
  rst_ctrl_if.slave  bus,
  output logic       o_sys_rst
);

  localparam int          DW        = $clog2(DEB_CYCLES + 1);
  localparam logic [7:0]  HOLD_INIT = 8'(RST_HOLD - 1);
  localparam logic [15:0] KEY_MAGIC = 16'hA5C3;

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_CLR} state_t;

  state_t          state, state_nxt;
  logic [7:0]      hold_cnt, hold_cnt_nxt;
  logic            btn_s1, btn_s2, btn_deb;
  logic [DW-1:0]   deb_cnt;
  logic [1:0]      ctrl;
  logic [3:0]      cause;
  logic            wr, rd, wr_cause, wr_ctrl, wr_key, sw_req;
  logic            btn_src, wdt_src, src_active;
  logic [3:0]      cause_set, cause_clr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= i_btn_n;
      btn_s2 <= btn_s1;
    end
  end

  // The counter only runs while the synchronized level disagrees with the debounced state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_deb <= 1'b0;
      deb_cnt <= '0;
    end else if (~btn_s2 == btn_deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
      btn_deb <= ~btn_s2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign wr         = bus.sel & bus.we;
  assign rd         = bus.sel & bus.re;
  assign wr_cause   = wr & (bus.addr == 2'd0);
  assign wr_ctrl    = wr & (bus.addr == 2'd1);
  assign wr_key     = wr & (bus.addr == 2'd3);
  assign sw_req     = wr_key & (bus.wdata == KEY_MAGIC);
  assign btn_src    = btn_deb & ctrl[1];
  assign wdt_src    = i_wdt_rst_req & ctrl[0];
  assign src_active = btn_src | wdt_src;
  assign cause_set  = {1'b0, sw_req, wdt_src, btn_src};
  assign cause_clr  = wr_cause ? bus.wdata[3:0] : 4'b0000;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl <= 2'b11;
    end else if (wr_ctrl) begin
      ctrl <= bus.wdata[1:0];
    end
  end

  // Set is ORed in after the clear so a simultaneous request keeps its flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cause <= 4'b1000;
    end else begin
      cause <= (cause & ~cause_clr) | cause_set;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ASSERT;
      hold_cnt <= HOLD_INIT;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        if (src_active | sw_req) begin
          state_nxt    = ASSERT;
          hold_cnt_nxt = HOLD_INIT;
        end
      end
      ASSERT: begin
        if (hold_cnt == 8'd0) begin
          state_nxt = src_active ? WAIT_CLR : IDLE;
        end else begin
          hold_cnt_nxt = hold_cnt - 8'd1;
        end
      end
      WAIT_CLR: begin
        if (!src_active) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        hold_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign o_sys_rst = i_rst | (state != IDLE);
  assign bus.rdy   = bus.sel;

  always_comb begin
    bus.rdata = 16'h0000;
    if (rd) begin
      case (bus.addr)
        2'd0:    bus.rdata = {12'h000, cause};
        2'd1:    bus.rdata = {14'h0000, ctrl};
        2'd2:    bus.rdata = {8'h00, hold_cnt};
        default: bus.rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_ctrl.sv
// Randomized scoreboard bench for rst_ctrl against a cycle-level behavioural model of the
// reset rules, plus directed reset-length checks.
module tb_rst_ctrl;
  localparam int DEB  = 16;
  localparam int HOLD = 16;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_btn_n;
  logic i_wdt_rst_req;
  logic o_sys_rst;

  rst_ctrl_if bus ();

  rst_ctrl #(.DEB_CYCLES(DEB), .RST_HOLD(HOLD)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_btn_n       (i_btn_n),
    .i_wdt_rst_req (i_wdt_rst_req),
    .bus           (bus),
    .o_sys_rst     (o_sys_rst)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic btn_lvl = 1'b1;
  logic wdt_lvl = 1'b0;
  int run_len  = 0;
  int last_run = 0;

  // Model: reset is a remaining-hold count plus an "in reset" flag; the button is a run-length
  // over synchronized samples.
  bit         m_in_rst   = 1'b1;
  int         m_left     = HOLD;
  logic [3:0] m_cause    = 4'b1000;
  logic [1:0] m_ctrl     = 2'b11;
  logic [1:0] m_pipe     = 2'b00;
  logic       m_run_val  = 1'b0;
  int         m_run_len  = 0;
  logic       m_deb      = 1'b0;

  always @(posedge i_clk) begin : model
    logic src, sw, btn_g, wdt_g, samp;
    logic [3:0] clr;
    if (i_rst) begin
      m_in_rst  = 1'b1;
      m_left    = HOLD;
      m_cause   = 4'b1000;
      m_ctrl    = 2'b11;
      m_pipe    = 2'b00;
      m_run_val = 1'b0;
      m_run_len = 0;
      m_deb     = 1'b0;
    end else begin
      btn_g = m_deb & m_ctrl[1];
      wdt_g = i_wdt_rst_req & m_ctrl[0];
      src   = btn_g | wdt_g;
      sw    = bus.sel & bus.we & (bus.addr == 2'd3) & (bus.wdata == 16'hA5C3);
      clr   = (bus.sel & bus.we & (bus.addr == 2'd0)) ? bus.wdata[3:0] : 4'b0000;
      m_cause = (m_cause & ~clr) | {1'b0, sw, wdt_g, btn_g};
      if (bus.sel & bus.we & (bus.addr == 2'd1)) m_ctrl = bus.wdata[1:0];
      if (!m_in_rst) begin
        if (src | sw) begin
          m_in_rst = 1'b1;
          m_left   = HOLD;
        end
      end else if (m_left > 1) begin
        m_left = m_left - 1;
      end else begin
        m_left   = 0;
        m_in_rst = src;
      end
      samp   = m_pipe[1];
      m_pipe = {m_pipe[0], i_btn_n};
      if (samp == m_run_val) m_run_len = m_run_len + 1;
      else begin
        m_run_val = samp;
        m_run_len = 1;
      end
      if (m_run_len >= DEB) m_deb = ~m_run_val;
    end
  end

  function automatic logic [15:0] expRead(input logic [1:0] a);
    case (a)
      2'd0:    return {12'h000, m_cause};
      2'd1:    return {14'h0000, m_ctrl};
      2'd2:    return (m_in_rst && m_left > 0) ? 16'(m_left - 1) : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic sel, input logic we, input logic re,
                               input logic [1:0] addr, input logic [15:0] wdata);
    @(posedge i_clk);
    #1;
    i_rst         = rst;
    i_btn_n       = btn_lvl;
    i_wdt_rst_req = wdt_lvl;
    bus.sel       = sel;
    bus.we        = we;
    bus.re        = re;
    bus.addr      = addr;
    bus.wdata     = wdata;
    if (sel & re) exp_q.push_back(expRead(addr));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic busRead(input logic [1:0] a);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, a, 16'h0000);
  endtask

  // Monitor: compares every cycle and pops the scoreboard on each ready read.
  always @(negedge i_clk) begin
    checkOutput("sys_rst", 16'(o_sys_rst), 16'(i_rst | m_in_rst));
    checkOutput("rdy", 16'(bus.rdy), 16'(bus.sel));
    if (bus.rdy & bus.re) begin
      if (exp_q.size() == 0) checkOutput("sb_underflow", 16'd1, 16'd0);
      else checkOutput("rdata", bus.rdata, exp_q.pop_front());
    end else begin
      checkOutput("rdata_idle", bus.rdata, 16'h0000);
    end
    if (o_sys_rst) run_len++;
    else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
  end

  initial begin
    int btn_hold, wdt_hold, rst_hold, r;
    i_rst = 1'b1; i_btn_n = 1'b1; i_wdt_rst_req = 1'b0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = 2'd0; bus.wdata = 16'h0000;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    idle(25);
    busRead(2'd0);
    busRead(2'd1);
    busRead(2'd2);

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    busRead(2'd2);
    idle(25);
    checkOutput("por_len", 16'(last_run), 16'(3 + HOLD));
    busRead(2'd0);

    wdt_lvl = 1'b1; idle(4); wdt_lvl = 1'b0;
    idle(25);
    checkOutput("wdt_len", 16'(last_run), 16'(HOLD));
    busRead(2'd0);
    busWrite(2'd0, 16'h0002);
    busRead(2'd0);

    btn_lvl = 1'b0; idle(10); btn_lvl = 1'b1; idle(30);
    busRead(2'd0);
    btn_lvl = 1'b0; idle(100); btn_lvl = 1'b1; idle(40);
    busRead(2'd0);
    busWrite(2'd0, 16'h000F);

    busWrite(2'd3, 16'h1234); idle(20);
    busWrite(2'd3, 16'hA5C3); busRead(2'd3); idle(25);
    checkOutput("key_len", 16'(last_run), 16'(HOLD));
    busRead(2'd0);

    busWrite(2'd1, 16'h0002);
    wdt_lvl = 1'b1; idle(4); wdt_lvl = 1'b0; idle(20);
    busRead(2'd0);
    btn_lvl = 1'b0; idle(40); btn_lvl = 1'b1; idle(40);
    busRead(2'd0);
    busWrite(2'd1, 16'h0003);
    busWrite(2'd0, 16'h000F);

    wdt_lvl = 1'b1; busWrite(2'd0, 16'h0002); wdt_lvl = 1'b0;
    busRead(2'd0); idle(4);
    wdt_lvl = 1'b1; idle(2); wdt_lvl = 1'b0;
    idle(25);
    checkOutput("wdt_noextend_len", 16'(last_run), 16'(HOLD));

    btn_hold = 0; wdt_hold = 0; rst_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (btn_hold == 0) begin
        btn_lvl  = ~btn_lvl;
        btn_hold = $urandom_range(1, 40);
      end
      btn_hold--;
      if (wdt_hold > 0) wdt_hold--;
      else if ($urandom_range(0, 99) < 3) wdt_hold = $urandom_range(1, 6);
      wdt_lvl = (wdt_hold > 0);
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 499) == 0) rst_hold = $urandom_range(1, 4);
      r = $urandom_range(0, 9);
      if (r <= 3) applyStimulus(rst_hold > 0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
      else if (r <= 6) applyStimulus(rst_hold > 0, 1'b1, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 16'h0000);
      else if (r == 7) applyStimulus(rst_hold > 0, 1'b1, 1'b1, 1'b0, 2'd0, 16'($urandom));
      else if (r == 8) applyStimulus(rst_hold > 0, 1'b1, 1'b1, $urandom_range(0, 1) == 1, 2'd1, 16'($urandom));
      else applyStimulus(rst_hold > 0, 1'b1, 1'b1, 1'b0, 2'd3,
                         ($urandom_range(0, 1) == 1) ? 16'hA5C3 : 16'($urandom));
    end

    btn_lvl = 1'b1; wdt_lvl = 1'b0;
    idle(60);
    busRead(2'd0);
    busRead(2'd2);
    idle(2);
    checkOutput("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
